voice_alloc: RTL and testbench
==============================

VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter VOICES, default 7: number of oscillator voices managed (2..15).
REQ-002 SHALL have parameter NOTE_BW, default 7: MIDI note width.
REQ-003 SHALL have parameter CH_BW, default 3: voice-index width, equal to clog2(VOICES+1).
REQ-004 SHALL have port clk_i, input, 1: single clock.
REQ-005 SHALL have port nrst_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port note_i, input, NOTE_BW: note number, valid with either input strobe.
REQ-007 SHALL have port noteOnStrb_i, input, 1: one-cycle note-on event from the MIDI decoder.
REQ-008 SHALL have port noteOffStrb_i, input, 1: one-cycle note-off event from the MIDI decoder.
REQ-009 SHALL have port ch_o, output, CH_BW: index of the target voice.
REQ-010 SHALL have port note_o, output, NOTE_BW: note for the target voice.
REQ-011 SHALL have port noteOnStrb_o, output, 1: one-cycle note-on to voice ch_o.
REQ-012 SHALL have port noteOffStrb_o, output, 1: one-cycle note-off to voice ch_o.
REQ-013 SHALL have port stolen_o, output, 1: one-cycle pulse, coincident with noteOnStrb_o, when an active voice is stolen.
REQ-014 SHALL have port busy_o, output, 1: high while an event is in flight.
REQ-015 SHALL have port active_o, output, VOICES: per-voice held flag.

Function
REQ-016 SHALL keep a per-voice table: active bit, note (NOTE_BW), rank (CH_BW).
REQ-017 SHALL implement the FSM IDLE -> LOOKUP -> ISSUE -> IDLE, one cycle each in LOOKUP and ISSUE.
REQ-018 SHALL, in IDLE, latch note_i and the event type on a strobe and move to LOOKUP.
REQ-019 SHALL give noteOffStrb_i priority when both input strobes arrive in the same cycle; the note-on is dropped.
REQ-020 SHALL ignore input strobes while busy_o=1, which holds in LOOKUP and ISSUE.
REQ-021 SHALL, in LOOKUP for note-on, select the target in this order: (a) an active voice already holding the note (retrigger); (b) the lowest-index inactive voice; (c) the active voice with maximum rank, lowest index on a tie (steal).
REQ-022 SHALL, in LOOKUP for note-off, select the lowest-index active voice holding the note; if none exists, no target.
REQ-023 SHALL, in ISSUE, drive ch_o and note_o for the target and pulse exactly one of noteOnStrb_o or noteOffStrb_o for one cycle; with no note-off target, no strobe pulses and ch_o/note_o remain unchanged.
REQ-024 SHALL have a fixed latency: input strobe in cycle N gives an output strobe in cycle N+2.
REQ-025 SHALL hold ch_o and note_o stable between ISSUE cycles.
REQ-026 SHALL, on note-on issue, set the target active with the note and rank 0, and increment the rank of every other active voice whose rank was below the target's previous rank (inactive target: treat the previous rank as VOICES-1), saturating at VOICES-1.
REQ-027 SHALL, on note-off issue, clear the target active bit and its rank to 0; other ranks are unchanged.
REQ-028 SHALL pulse stolen_o only in case (c) of REQ-021.
REQ-029 SHALL update active_o in the ISSUE cycle (table write visible the following cycle).
REQ-030 SHALL constrain rank values to 0..VOICES-1 for all active voices.

Reset
REQ-031 SHALL, with nrst_i low, asynchronously set the FSM to IDLE, clear all table entries, and drive ch_o=0, note_o=0, noteOnStrb_o=0, noteOffStrb_o=0, stolen_o=0, busy_o=0, active_o=0.
REQ-032 SHALL, on reset asserted mid-event (LOOKUP or ISSUE), abort the event with no output strobe after reset release.
REQ-033 SHALL accept a new strobe in the first clock edge after nrst_i deasserts.

Verification
REQ-034 Reset, then note-on 60 -> two cycles later noteOnStrb_o=1, ch_o=0, note_o=60; active_o=0000001.
REQ-035 Note-on for notes 60..66 (7 voices), then note-on 70 -> ch_o=0 (oldest), stolen_o=1, note_o=70.
REQ-036 Note-on 60, note-on 62, note-off 60 -> noteOffStrb_o=1, ch_o=0; then note-on 64 -> ch_o=0.
REQ-037 Note-off 50 with no voice holding 50 -> no output strobe; ch_o/note_o unchanged; busy_o high for 2 cycles.
REQ-038 Simultaneous noteOnStrb_i and noteOffStrb_i with note 60 held on voice 0 -> only noteOffStrb_o, ch_o=0; plus a strobe during busy_o -> ignored.
REQ-039 Note-on 60 twice -> second targets ch_o=0 again, stolen_o=0, active_o=0000001.

Source files
------------

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto VOICES oscillator
// voices using a per-voice active/note/rank table, with oldest-voice stealing.
module voice_alloc #(
  parameter int VOICES  = 7,
  parameter int NOTE_BW = 7,
  parameter int CH_BW   = 3
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic [NOTE_BW-1:0] note_i,
  input  logic               noteOnStrb_i,
  input  logic               noteOffStrb_i,
  output logic [CH_BW-1:0]   ch_o,
  output logic [NOTE_BW-1:0] note_o,
  output logic               noteOnStrb_o,
  output logic               noteOffStrb_o,
  output logic               stolen_o,
  output logic               busy_o,
  output logic [VOICES-1:0]  active_o,
  output logic [1:0]         dbgState_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] ISSUE  = 2'd2;
  localparam logic [CH_BW-1:0] MAX_RANK = CH_BW'(VOICES - 1);

  logic [1:0]         state;
  logic [NOTE_BW-1:0] evNote;
  logic               evIsOff;
  logic [CH_BW-1:0]   tgt;
  logic [CH_BW-1:0]   tgtPrevRank;
  logic               tgtValid;

  logic [VOICES-1:0]  active;
  logic [NOTE_BW-1:0] notes [VOICES];
  logic [CH_BW-1:0]   ranks [VOICES];

  logic               hitFound, freeFound;
  logic [CH_BW-1:0]   hitIdx, freeIdx, stealIdx, stealRank;
  logic [CH_BW-1:0]   lkTgt, lkPrevRank;
  logic               lkValid, lkSteal;

  // Input strobes are one-cycle events accepted only while busy_o is low;
  // any strobe seen while busy_o is high is dropped, never queued.
  assign busy_o     = (state != IDLE);
  assign active_o   = active;
  assign dbgState_o = state;

  always_comb begin
    hitFound   = 1'b0;
    hitIdx     = '0;
    freeFound  = 1'b0;
    freeIdx    = '0;
    stealIdx   = '0;
    stealRank  = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!hitFound && active[i] && notes[i] == evNote) begin
        hitFound = 1'b1;
        hitIdx   = CH_BW'(i);
      end
      if (!freeFound && !active[i]) begin
        freeFound = 1'b1;
        freeIdx   = CH_BW'(i);
      end
      // Strict compare keeps the lowest index on a rank tie.
      if (active[i] && ranks[i] > stealRank) begin
        stealRank = ranks[i];
        stealIdx  = CH_BW'(i);
      end
    end

    lkTgt      = '0;
    lkPrevRank = MAX_RANK;
    lkValid    = 1'b0;
    lkSteal    = 1'b0;
    if (evIsOff) begin
      lkValid = hitFound;
      lkTgt   = hitIdx;
    end else if (hitFound) begin
      lkValid    = 1'b1;
      lkTgt      = hitIdx;
      lkPrevRank = ranks[hitIdx];
    end else if (freeFound) begin
      lkValid = 1'b1;
      lkTgt   = freeIdx;
    end else begin
      lkValid    = 1'b1;
      lkSteal    = 1'b1;
      lkTgt      = stealIdx;
      lkPrevRank = ranks[stealIdx];
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state         <= IDLE;
      evNote        <= '0;
      evIsOff       <= 1'b0;
      tgt           <= '0;
      tgtPrevRank   <= '0;
      tgtValid      <= 1'b0;
      active        <= '0;
      ch_o          <= '0;
      note_o        <= '0;
      noteOnStrb_o  <= 1'b0;
      noteOffStrb_o <= 1'b0;
      stolen_o      <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        notes[i] <= '0;
        ranks[i] <= '0;
      end
    end else begin
      noteOnStrb_o  <= 1'b0;
      noteOffStrb_o <= 1'b0;
      stolen_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (noteOffStrb_i || noteOnStrb_i) begin
            evNote  <= note_i;
            evIsOff <= noteOffStrb_i;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          tgt         <= lkTgt;
          tgtPrevRank <= lkPrevRank;
          tgtValid    <= lkValid;
          if (lkValid) begin
            ch_o          <= lkTgt;
            note_o        <= evNote;
            noteOnStrb_o  <= !evIsOff;
            noteOffStrb_o <= evIsOff;
            stolen_o      <= lkSteal;
          end
          state <= ISSUE;
        end
        ISSUE: begin
          if (tgtValid) begin
            for (int i = 0; i < VOICES; i++) begin
              if (CH_BW'(i) == tgt) begin
                active[i] <= !evIsOff;
                ranks[i]  <= '0;
                if (!evIsOff) notes[i] <= evNote;
              end else if (!evIsOff && active[i] && ranks[i] < tgtPrevRank
                           && ranks[i] < MAX_RANK) begin
                ranks[i] <= ranks[i] + CH_BW'(1);
              end
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Randomized bench for voice_alloc against an array-based model of the
// allocation rules (retrigger / free voice / steal oldest, rank ageing).
module tb_voice_alloc;
  localparam int VOICES  = 7;
  localparam int NOTE_BW = 7;
  localparam int CH_BW   = 3;

  logic               clk_i = 1'b0;
  logic               nrst_i = 1'b0;
  logic [NOTE_BW-1:0] note_i = '0;
  logic               noteOnStrb_i = 1'b0;
  logic               noteOffStrb_i = 1'b0;
  logic [CH_BW-1:0]   ch_o;
  logic [NOTE_BW-1:0] note_o;
  logic               noteOnStrb_o, noteOffStrb_o, stolen_o, busy_o;
  logic [VOICES-1:0]  active_o;
  logic [1:0]         dbgState_o;

  voice_alloc #(.VOICES(VOICES), .NOTE_BW(NOTE_BW), .CH_BW(CH_BW)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .note_i(note_i),
    .noteOnStrb_i(noteOnStrb_i), .noteOffStrb_i(noteOffStrb_i),
    .ch_o(ch_o), .note_o(note_o), .noteOnStrb_o(noteOnStrb_o),
    .noteOffStrb_o(noteOffStrb_o), .stolen_o(stolen_o), .busy_o(busy_o),
    .active_o(active_o), .dbgState_o(dbgState_o)
  );

  always #5 clk_i = ~clk_i;

  int nChecks = 0;
  int nBad    = 0;

  bit mAct [VOICES];
  int mNote[VOICES];
  int mRank[VOICES];
  int mCh, mNoteOut;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelActive();
    logic [31:0] v = '0;
    for (int i = 0; i < VOICES; i++) v[i] = mAct[i];
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < VOICES; i++) begin
      mAct[i] = 0; mNote[i] = 0; mRank[i] = 0;
    end
    mCh = 0; mNoteOut = 0;
  endtask

  // Drives one event and checks the LOOKUP, ISSUE and following IDLE cycles.
  task automatic sendEvent(input bit on, input bit off, input int note, input bit noise);
    int  tgt = -1;
    int  prev;
    bit  valid = 0;
    bit  steal = 0;
    bit  isOff = off;
    bit  isOn  = on && !off;
    for (int i = 0; i < VOICES; i++)
      if (tgt < 0 && mAct[i] && mNote[i] == note) tgt = i;
    if (isOff) valid = (tgt >= 0);
    else if (isOn) begin
      valid = 1;
      if (tgt < 0)
        for (int i = 0; i < VOICES; i++) if (tgt < 0 && !mAct[i]) tgt = i;
      if (tgt < 0) begin
        steal = 1;
        tgt = 0;
        for (int i = 1; i < VOICES; i++) if (mRank[i] > mRank[tgt]) tgt = i;
      end
    end
    prev = (valid && mAct[tgt]) ? mRank[tgt] : VOICES - 1;

    note_i = NOTE_BW'(note); noteOnStrb_i = on; noteOffStrb_i = off;
    @(posedge clk_i); #1;
    noteOnStrb_i = 0; noteOffStrb_i = 0;
    checkVal("lookup_busy", busy_o, 1);
    checkVal("lookup_strb", {noteOnStrb_o, noteOffStrb_o}, 0);
    if (noise) begin
      note_i = NOTE_BW'($urandom_range(0, 127));
      noteOnStrb_i = 1'b1;
      noteOffStrb_i = $urandom_range(0, 1);
    end
    @(posedge clk_i); #1;
    noteOnStrb_i = 0; noteOffStrb_i = 0;
    if (valid) begin mCh = tgt; mNoteOut = note; end
    checkVal("issue_on",     noteOnStrb_o,  valid && isOn);
    checkVal("issue_off",    noteOffStrb_o, valid && isOff);
    checkVal("issue_stolen", stolen_o,      steal);
    checkVal("issue_ch",     ch_o,          mCh);
    checkVal("issue_note",   note_o,        mNoteOut);
    checkVal("issue_busy",   busy_o,        1);
    if (valid && isOn) begin
      for (int i = 0; i < VOICES; i++)
        if (i != tgt && mAct[i] && mRank[i] < prev && mRank[i] < VOICES - 1) mRank[i]++;
      mAct[tgt] = 1; mNote[tgt] = note; mRank[tgt] = 0;
    end else if (valid) begin
      mAct[tgt] = 0; mRank[tgt] = 0;
    end
    @(posedge clk_i); #1;
    checkVal("idle_busy",   busy_o, 0);
    checkVal("idle_strb",   {noteOnStrb_o, noteOffStrb_o, stolen_o}, 0);
    checkVal("idle_active", active_o, modelActive());
  endtask

  task automatic resetDut();
    nrst_i = 0;
    @(posedge clk_i); #1;
    nrst_i = 1;
    modelReset();
  endtask

  initial begin
    modelReset();
    #1;
    checkVal("rst_ch",     ch_o, 0);
    checkVal("rst_note",   note_o, 0);
    checkVal("rst_strb",   {noteOnStrb_o, noteOffStrb_o, stolen_o}, 0);
    checkVal("rst_busy",   busy_o, 0);
    checkVal("rst_active", active_o, 0);
    @(posedge clk_i); #1;
    nrst_i = 1;

    // First note lands on voice 0, accepted on the first edge after release.
    sendEvent(1, 0, 60, 0);
    checkVal("first_active", active_o, 7'b0000001);

    // Fill all voices, then steal the oldest.
    resetDut();
    for (int n = 60; n <= 66; n++) sendEvent(1, 0, n, 0);
    sendEvent(1, 0, 70, 0);
    checkVal("steal_ch", ch_o, 0);

    // Note-off frees voice 0, next note-on reuses it.
    resetDut();
    sendEvent(1, 0, 60, 0);
    sendEvent(1, 0, 62, 0);
    sendEvent(0, 1, 60, 0);
    sendEvent(1, 0, 64, 0);
    checkVal("reuse_ch", ch_o, 0);

    // Note-off for an unheld note: no strobe, outputs held.
    sendEvent(0, 1, 50, 0);

    // Simultaneous strobes: off wins; strobe during busy is ignored.
    resetDut();
    sendEvent(1, 0, 60, 0);
    sendEvent(1, 1, 60, 1);
    checkVal("both_active", active_o, 0);

    // Retrigger keeps the same voice without stealing.
    resetDut();
    sendEvent(1, 0, 60, 0);
    sendEvent(1, 0, 60, 0);
    checkVal("retrig_active", active_o, 7'b0000001);

    // Reset during LOOKUP aborts the event.
    sendEvent(1, 0, 61, 0);
    note_i = 7'd62; noteOnStrb_i = 1;
    @(posedge clk_i); #1;
    noteOnStrb_i = 0;
    nrst_i = 0;
    #1;
    checkVal("midrst_busy",   busy_o, 0);
    checkVal("midrst_active", active_o, 0);
    checkVal("midrst_ch",     ch_o, 0);
    @(posedge clk_i); #1;
    nrst_i = 1;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      checkVal("midrst_nostrb", {noteOnStrb_o, noteOffStrb_o, busy_o}, 0);
    end

    // Randomized traffic over a narrow note range to force hits and steals.
    for (int k = 0; k < 400; k++) begin
      int r = $urandom_range(0, 9);
      int n = 60 + $urandom_range(0, 9);
      bit noise = ($urandom_range(0, 3) == 0);
      if (r < 5)      sendEvent(1, 0, n, noise);
      else if (r < 9) sendEvent(0, 1, n, noise);
      else            sendEvent(1, 1, n, noise);
      if ($urandom_range(0, 3) == 0) @(posedge clk_i);
      #0;
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
